// File: rtl/arith_pipe_pkg.sv
// Shared types and helpers for the arith_pipe arithmetic unit.
package arith_pipe_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_SUB    = 3'd0,
      MODE_ADD    = 3'd1,
      MODE_SUBS   = 3'd2,
      MODE_ADDS   = 3'd3,
      MODE_ABSD   = 3'd4,
      MODE_ACCADD = 3'd5,
      MODE_ACCSUB = 3'd6,
      MODE_ACCLD  = 3'd7
   } mode_t;

   typedef struct packed {
      logic carry;
      logic zero;
      logic sat;
   } flags_t;

   // True for the modes that read and write the running accumulator.
   function automatic logic is_acc_mode(input mode_t mode);
      logic res;
      case (mode)
         MODE_ACCADD, MODE_ACCSUB, MODE_ACCLD: res = 1'b1;
         default:                              res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/arith_pipe_if.sv
// Operand/result handshake bundle between producer, arith_pipe and consumer.
interface arith_pipe_if #(
   parameter int WIDTH = 8
);
   import arith_pipe_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   mode_t            in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_zero;
   logic             out_sat;

   // Producer/consumer side (drives operands and result-ready).
   modport master (
      output in_valid, in_a, in_b, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_carry, out_zero, out_sat
   );

   // Arithmetic unit side.
   modport slave (
      input  in_valid, in_a, in_b, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_carry, out_zero, out_sat
   );

endinterface

// File: rtl/arith_pipe_alu.sv
// Stateless datapath: one WIDTH+1-bit add/sub per mode, result, flags and accumulator update.
module arith_pipe_alu
   import arith_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] acc_i,
   input  mode_t            mode_i,
   output logic [WIDTH-1:0] result_o,
   output flags_t           flags_o,
   output logic [WIDTH-1:0] acc_next_o,
   output logic             acc_we_o
);

   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   // The extra top bit carries the carry-out / borrow before any wrap or clamp.
   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;
   logic [WIDTH:0] rdiff;
   logic [WIDTH:0] acc_sum;
   logic [WIDTH:0] acc_diff;

   assign sum      = {1'b0, a_i}   + {1'b0, b_i};
   assign diff     = {1'b0, a_i}   - {1'b0, b_i};
   assign rdiff    = {1'b0, b_i}   - {1'b0, a_i};
   assign acc_sum  = {1'b0, acc_i} + {1'b0, a_i};
   assign acc_diff = {1'b0, acc_i} - {1'b0, a_i};

   // Select result, flags and accumulator update for the requested mode.
   always_comb begin
      result_o      = ZERO;
      flags_o.carry = 1'b0;
      flags_o.sat   = 1'b0;
      acc_next_o    = acc_i;
      acc_we_o      = is_acc_mode(mode_i);
      case (mode_i)
         MODE_SUB: begin
            result_o      = diff[WIDTH-1:0];
            flags_o.carry = diff[WIDTH];
         end
         MODE_ADD: begin
            result_o      = sum[WIDTH-1:0];
            flags_o.carry = sum[WIDTH];
         end
         MODE_SUBS: begin
            result_o    = diff[WIDTH] ? ZERO : diff[WIDTH-1:0];
            flags_o.sat = diff[WIDTH];
         end
         MODE_ADDS: begin
            result_o    = sum[WIDTH] ? ALL_ONES : sum[WIDTH-1:0];
            flags_o.sat = sum[WIDTH];
         end
         MODE_ABSD: begin
            result_o      = diff[WIDTH] ? rdiff[WIDTH-1:0] : diff[WIDTH-1:0];
            flags_o.carry = diff[WIDTH];
         end
         MODE_ACCADD: begin
            result_o      = acc_sum[WIDTH-1:0];
            flags_o.carry = acc_sum[WIDTH];
            acc_next_o    = acc_sum[WIDTH-1:0];
         end
         MODE_ACCSUB: begin
            result_o      = acc_diff[WIDTH-1:0];
            flags_o.carry = acc_diff[WIDTH];
            acc_next_o    = acc_diff[WIDTH-1:0];
         end
         MODE_ACCLD: begin
            result_o   = a_i;
            acc_next_o = a_i;
         end
         default: begin
            result_o = ZERO;
         end
      endcase
      flags_o.zero = (result_o == ZERO);
   end

endmodule

// File: rtl/arith_pipe.sv
// Two-stage arithmetic pipeline: S1 captures operands, S2 holds the registered result.
module arith_pipe
   import arith_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic         clk,
   input logic         rst,
   arith_pipe_if.slave bus
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   mode_t            s1_mode_q, s1_mode_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_data_q, s2_data_d;
   flags_t           s2_flags_q, s2_flags_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             s2_adv;
   logic             in_fire;
   logic             s1_move;
   logic [WIDTH-1:0] alu_result;
   flags_t           alu_flags;
   logic [WIDTH-1:0] alu_acc_next;
   logic             alu_acc_we;

   // in_ready is the only combinational input-to-output path (through out_ready).
   assign s2_adv       = !s2_valid_q || bus.out_ready;
   assign bus.in_ready = !s1_valid_q || s2_adv;
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign s1_move      = s1_valid_q && s2_adv;

   arith_pipe_alu #(.WIDTH(WIDTH)) u_alu (
      .a_i        (s1_a_q),
      .b_i        (s1_b_q),
      .acc_i      (acc_q),
      .mode_i     (s1_mode_q),
      .result_o   (alu_result),
      .flags_o    (alu_flags),
      .acc_next_o (alu_acc_next),
      .acc_we_o   (alu_acc_we)
   );

   // S1 next state: load on a handshake, empty when drained, otherwise hold.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_mode_d  = s1_mode_q;
      if (bus.in_ready) begin
         s1_valid_d = bus.in_valid;
      end else begin
         s1_valid_d = s1_valid_q;
      end
      if (in_fire) begin
         s1_a_d    = bus.in_a;
         s1_b_d    = bus.in_b;
         s1_mode_d = bus.in_mode;
      end else begin
         s1_a_d    = s1_a_q;
         s1_b_d    = s1_b_q;
         s1_mode_d = s1_mode_q;
      end
   end

   // S2 and accumulator next state: acc changes only as an acc op moves S1->S2, so chained ops see it next cycle.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_flags_d = s2_flags_q;
      acc_d      = acc_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
      end else begin
         s2_valid_d = s2_valid_q;
      end
      if (s1_move) begin
         s2_data_d  = alu_result;
         s2_flags_d = alu_flags;
         if (alu_acc_we) begin
            acc_d = alu_acc_next;
         end else begin
            acc_d = acc_q;
         end
      end else begin
         s2_data_d  = s2_data_q;
         s2_flags_d = s2_flags_q;
         acc_d      = acc_q;
      end
   end

   // Pipeline state registers; synchronous reset discards any in-flight beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= {WIDTH{1'b0}};
         s1_b_q     <= {WIDTH{1'b0}};
         s1_mode_q  <= MODE_SUB;
         s2_valid_q <= 1'b0;
         s2_data_q  <= {WIDTH{1'b0}};
         s2_flags_q <= 3'b000;
         acc_q      <= {WIDTH{1'b0}};
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_flags_q <= s2_flags_d;
         acc_q      <= acc_d;
      end
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = s2_data_q;
   assign bus.out_carry = s2_flags_q.carry;
   assign bus.out_zero  = s2_flags_q.zero;
   assign bus.out_sat   = s2_flags_q.sat;

endmodule

// File: tb/tb_arith_pipe.sv
// Self-checking bench for arith_pipe (WIDTH=8 main instance, WIDTH=4 side instance).
module tb_arith_pipe;
   import arith_pipe_pkg::*;

   typedef struct {
      int d;
      bit c;
      bit z;
      bit s;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   arith_pipe_if #(.WIDTH(8)) if8 ();
   arith_pipe_if #(.WIDTH(4)) if4 ();

   arith_pipe #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
   arith_pipe #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

   // Reference model straight from the mode table, using plain integer arithmetic.
   task automatic ref_op(input int w, input int m, input int a, input int b, inout int acc,
                         output int d, output bit c, output bit z, output bit s);
      int mx;
      mx = (1 << w) - 1;
      c = 1'b0;
      s = 1'b0;
      d = 0;
      case (m)
         0: begin d = (a - b) & mx; c = (a < b); end
         1: begin d = (a + b) & mx; c = (a + b > mx); end
         2: begin d = (a < b) ? 0 : a - b; s = (a < b); end
         3: begin d = (a + b > mx) ? mx : a + b; s = (a + b > mx); end
         4: begin d = (a >= b) ? a - b : b - a; c = (a < b); end
         5: begin c = (acc + a > mx); acc = (acc + a) & mx; d = acc; end
         6: begin c = (a > acc); acc = (acc - a) & mx; d = acc; end
         default: begin acc = a; d = a; end
      endcase
      z = (d == 0);
   endtask

   task automatic drive8(input bit v, input int m, input int a, input int b, input bit rdy);
      if8.in_valid  = v;
      if8.in_mode   = mode_t'(m[2:0]);
      if8.in_a      = 8'(a);
      if8.in_b      = 8'(b);
      if8.out_ready = rdy;
   endtask

   // Offer one beat with out_ready high and capture its result (bounded waits).
   task automatic send_one8(input int m, input int a, input int b,
                            output int d, output bit c, output bit z, output bit s, output bit ok);
      bit acc_ok;
      ok = 1'b0;
      acc_ok = 1'b0;
      d = -1; c = 1'b0; z = 1'b0; s = 1'b0;
      @(negedge clk);
      drive8(1'b1, m, a, b, 1'b1);
      for (int k = 0; k < 20; k++) begin
         #1;
         if (if8.in_ready) begin
            acc_ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      drive8(1'b0, 0, 0, 0, 1'b1);
      if (acc_ok) begin
         for (int k = 0; k < 20; k++) begin
            #1;
            if (if8.out_valid) begin
               d = int'(if8.out_data); c = if8.out_carry; z = if8.out_zero; s = if8.out_sat;
               ok = 1'b1;
               break;
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive8(1'b0, 0, 0, 0, 1'b0);
      if4.in_valid = 1'b0; if4.in_a = 4'd0; if4.in_b = 4'd0;
      if4.in_mode = MODE_SUB; if4.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (if8.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", if8.out_valid); end
      n_cmp++; if (if8.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", if8.in_ready); end
      n_cmp++; if (if8.out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %h want 00", if8.out_data); end
      n_cmp++;
      if ({if8.out_carry, if8.out_zero, if8.out_sat} !== 3'b000) begin
         n_bad++; $display("FAIL reset_flags got %b want 000", {if8.out_carry, if8.out_zero, if8.out_sat});
      end
   endtask

   task automatic test_sub_subs();
      int d; bit c, z, s, ok;
      send_one8(0, 5, 7, d, c, z, s, ok);
      n_cmp++;
      if (!ok || d !== 254 || c !== 1'b1 || s !== 1'b0) begin
         n_bad++; $display("FAIL sub_5_7 got ok=%0b d=%0d c=%0b s=%0b want d=254 c=1 s=0", ok, d, c, s);
      end
      send_one8(2, 5, 7, d, c, z, s, ok);
      n_cmp++;
      if (!ok || d !== 0 || s !== 1'b1 || z !== 1'b1 || c !== 1'b0) begin
         n_bad++; $display("FAIL subs_5_7 got ok=%0b d=%0d c=%0b z=%0b s=%0b want d=0 c=0 z=1 s=1", ok, d, c, z, s);
      end
   endtask

   task automatic test_add_adds();
      int d; bit c, z, s, ok;
      send_one8(3, 200, 100, d, c, z, s, ok);
      n_cmp++;
      if (!ok || d !== 255 || s !== 1'b1 || c !== 1'b0) begin
         n_bad++; $display("FAIL adds_200_100 got ok=%0b d=%0d c=%0b s=%0b want d=255 c=0 s=1", ok, d, c, s);
      end
      send_one8(1, 200, 100, d, c, z, s, ok);
      n_cmp++;
      if (!ok || d !== 44 || c !== 1'b1 || s !== 1'b0) begin
         n_bad++; $display("FAIL add_200_100 got ok=%0b d=%0d c=%0b s=%0b want d=44 c=1 s=0", ok, d, c, s);
      end
   endtask

   task automatic test_acc_stream();
      int modes[4] = '{7, 5, 6, 5};
      int as[4]    = '{10, 5, 20, 255};
      int wd[4]    = '{10, 15, 251, 250};
      bit wc[4]    = '{1'b0, 1'b0, 1'b1, 1'b1};
      int got_cyc[$];
      int got_d[$];
      bit got_c[$];
      for (int cyc = 0; cyc < 9; cyc++) begin
         @(negedge clk);
         if (cyc < 4) drive8(1'b1, modes[cyc], as[cyc], $urandom_range(0, 255), 1'b1);
         else         drive8(1'b0, 0, 0, 0, 1'b1);
         #1;
         if (if8.out_valid) begin
            got_cyc.push_back(cyc); got_d.push_back(int'(if8.out_data)); got_c.push_back(if8.out_carry);
         end
      end
      n_cmp++;
      if (got_cyc.size() != 4) begin
         n_bad++; $display("FAIL acc_stream_count got %0d want 4", got_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_cyc[i] != 2 + i || got_d[i] !== wd[i] || got_c[i] !== wc[i]) begin
               n_bad++;
               $display("FAIL acc_stream_%0d got cyc=%0d d=%0d c=%0b want cyc=%0d d=%0d c=%0b",
                        i, got_cyc[i], got_d[i], got_c[i], 2 + i, wd[i], wc[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int bm[3] = '{1, 0, 4};
      int ba[3] = '{1, 9, 3};
      int bb[3] = '{2, 4, 10};
      int wd[3] = '{3, 5, 7};
      int nacc = 0;
      int nout = 0;
      logic [10:0] held;
      bit have_held = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         if (nacc < 3) drive8(1'b1, bm[nacc], ba[nacc], bb[nacc], 1'b0);
         else          drive8(1'b0, 0, 0, 0, 1'b0);
         #1;
         if (have_held) begin
            n_cmp++;
            if ({if8.out_valid, if8.out_data, if8.out_carry, if8.out_sat} !== held) begin
               n_bad++; $display("FAIL bp_stable got %h want %h",
                                 {if8.out_valid, if8.out_data, if8.out_carry, if8.out_sat}, held);
            end
         end
         if (if8.out_valid) begin
            held = {if8.out_valid, if8.out_data, if8.out_carry, if8.out_sat};
            have_held = 1'b1;
         end
         if (if8.in_valid && if8.in_ready) nacc++;
      end
      n_cmp++;
      if (nacc != 2 || if8.in_ready !== 1'b0) begin
         n_bad++; $display("FAIL bp_full got accepted=%0d in_ready=%b want accepted=2 in_ready=0", nacc, if8.in_ready);
      end
      for (int cyc = 0; cyc < 20 && nout < 3; cyc++) begin
         @(negedge clk);
         if (nacc < 3) drive8(1'b1, bm[nacc], ba[nacc], bb[nacc], 1'b1);
         else          drive8(1'b0, 0, 0, 0, 1'b1);
         #1;
         if (if8.in_valid && if8.in_ready) nacc++;
         if (if8.out_valid && if8.out_ready) begin
            n_cmp++;
            if (int'(if8.out_data) !== wd[nout]) begin
               n_bad++; $display("FAIL bp_drain_%0d got %0d want %0d", nout, if8.out_data, wd[nout]);
            end
            nout++;
         end
      end
      @(negedge clk);
      drive8(1'b0, 0, 0, 0, 1'b1);
      #1;
      n_cmp++;
      if (nout != 3 || if8.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL bp_drain_total got %0d extra_valid=%b want 3 and 0", nout, if8.out_valid);
      end
   endtask

   task automatic test_reset_midstream();
      int d; bit c, z, s, ok;
      @(negedge clk); drive8(1'b1, 5, 7, 0, 1'b0);
      @(negedge clk); drive8(1'b1, 5, 9, 0, 1'b0);
      @(negedge clk); drive8(1'b1, 5, 50, 0, 1'b0);
      #1;
      n_cmp++;
      if (if8.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_full_in_ready got %b want 0", if8.in_ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive8(1'b0, 0, 0, 0, 1'b0);
      #1;
      n_cmp++;
      if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL mid_reset got out_valid=%b in_ready=%b want 0 1", if8.out_valid, if8.in_ready);
      end
      send_one8(5, 3, 0, d, c, z, s, ok);
      n_cmp++;
      if (!ok || d !== 3 || c !== 1'b0 || z !== 1'b0) begin
         n_bad++; $display("FAIL mid_accadd3 got ok=%0b d=%0d c=%0b z=%0b want d=3 c=0 z=0", ok, d, c, z);
      end
      // Wrap: acc=3, load 255 then add 1.
      send_one8(7, 255, 0, d, c, z, s, ok);
      send_one8(5, 1, 0, d, c, z, s, ok);
      n_cmp++;
      if (!ok || d !== 0 || c !== 1'b1 || z !== 1'b1) begin
         n_bad++; $display("FAIL acc_wrap got ok=%0b d=%0d c=%0b z=%0b want d=0 c=1 z=1", ok, d, c, z);
      end
   endtask

   task automatic test_width4();
      int wd[2] = '{9, 7};
      int nout = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         if4.out_ready = 1'b1;
         if (cyc == 0) begin
            if4.in_valid = 1'b1; if4.in_mode = MODE_ABSD; if4.in_a = 4'd3; if4.in_b = 4'd12;
         end else if (cyc == 1) begin
            if4.in_valid = 1'b1; if4.in_mode = MODE_SUB; if4.in_a = 4'd3; if4.in_b = 4'd12;
         end else begin
            if4.in_valid = 1'b0;
         end
         #1;
         if (if4.out_valid && nout < 2) begin
            n_cmp++;
            if (int'(if4.out_data) !== wd[nout] || if4.out_carry !== 1'b1) begin
               n_bad++; $display("FAIL w4_beat%0d got d=%0d c=%b want d=%0d c=1", nout, if4.out_data, if4.out_carry, wd[nout]);
            end
            nout++;
         end
      end
      n_cmp++;
      if (nout != 2) begin n_bad++; $display("FAIL w4_count got %0d want 2", nout); end
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      int   acc_m = 0;
      int   sent = 0;
      int   cyc = 0;
      int   m, a, b;
      bit   v, rdy, prev_hold;
      logic [11:0] prev;
      rst = 1'b1;
      drive8(1'b0, 0, 0, 0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      prev_hold = 1'b0;
      prev = 12'h000;
      while ((sent < 10000 || q.size() > 0) && cyc < 80000) begin
         @(negedge clk);
         v   = (sent < 10000) && ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         m   = $urandom_range(0, 7);
         a   = $urandom_range(0, 255);
         b   = $urandom_range(0, 255);
         drive8(v, m, a, b, rdy);
         #1;
         if (prev_hold) begin
            n_cmp++;
            if ({if8.out_valid, if8.out_data, if8.out_carry, if8.out_zero, if8.out_sat} !== prev) begin
               n_bad++; $display("FAIL rnd_hold cyc=%0d got %h want %h", cyc,
                                 {if8.out_valid, if8.out_data, if8.out_carry, if8.out_zero, if8.out_sat}, prev);
            end
         end
         if (v && if8.in_ready) begin
            ref_op(8, m, a, b, acc_m, e.d, e.c, e.z, e.s);
            q.push_back(e);
            sent++;
         end
         if (if8.out_valid && rdy) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++; $display("FAIL rnd_extra cyc=%0d got d=%0d want no output", cyc, if8.out_data);
            end else begin
               e = q.pop_front();
               if (int'(if8.out_data) !== e.d || if8.out_carry !== e.c || if8.out_zero !== e.z || if8.out_sat !== e.s) begin
                  n_bad++;
                  $display("FAIL rnd_data cyc=%0d got d=%0d c=%b z=%b s=%b want d=%0d c=%0b z=%0b s=%0b",
                           cyc, if8.out_data, if8.out_carry, if8.out_zero, if8.out_sat, e.d, e.c, e.z, e.s);
               end
            end
         end
         prev_hold = if8.out_valid && !rdy;
         prev = {if8.out_valid, if8.out_data, if8.out_carry, if8.out_zero, if8.out_sat};
         cyc++;
      end
      n_cmp++;
      if (sent != 10000 || q.size() != 0) begin
         n_bad++; $display("FAIL rnd_timeout got sent=%0d pending=%0d want 10000 and 0", sent, q.size());
      end
      @(negedge clk);
      drive8(1'b0, 0, 0, 0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_sub_subs();
      test_add_adds();
      test_acc_stream();
      test_backpressure();
      test_reset_midstream();
      test_width4();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
